// File: rtl/serial_tx_byte.sv
// serial_tx_byte
//   Parallel-in, serial-out transmitter for the byte-serial link. A WIDTH-bit
//   word is taken through a valid/ready handshake and sent LSB first, one bit
//   per tick, with a per-bit strobe (so_en) that drives the far-end receiver's
//   en input. An optional GAP of idle ticks follows every frame.
//
//   Optional feature (macro SERIAL_TX_PARITY_EN): appends one even-parity bit
//   (XOR of the loaded word) after the data bits, giving WIDTH+1 strobes.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous, active-high reset
//   tick        in   bit-rate enable; SHIFT/GAP/PARITY advance only on tick
//   load_valid  in   din holds a word to send
//   din         in   [WIDTH-1:0] parallel word
//   load_ready  out  block can accept a word (IDLE)
//   so          out  serial data
//   so_en       out  so holds a valid bit this cycle
//   busy        out  frame or gap in progress
//   done        out  one-cycle pulse after the last bit of a frame
module serial_tx_byte #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             so,
    output logic             so_en,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
`ifdef SERIAL_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    // Where a frame goes once its final bit has been sent.
    localparam state_t END_STATE = (GAP > 0) ? S_GAP : S_IDLE;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            // Acceptance ignores tick: load_ready is simply "in IDLE".
            S_IDLE: begin
                if (load_valid) begin
                    sr_d    = din;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    sr_d  = {1'b0, sr_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = END_STATE;
                        gcnt_d  = '0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gcnt_q == LAST_GAP) begin
                        gcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = END_STATE;
                    gcnt_d  = '0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // so follows the register directly, so it holds between ticks; so_en is
    // the strobe and only qualifies cycles where a bit is actually consumed.
    always_comb begin
        so    = 1'b0;
        so_en = 1'b0;
        case (state_q)
            S_SHIFT: begin
                so    = sr_q[0];
                so_en = tick;
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                so    = par_q;
                so_en = tick;
            end
`endif
            default: ;
        endcase
    end

    // Held low while rst is asserted so no handshake can complete in reset.
    assign load_ready = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_serial_tx_byte.sv
// Bench for serial_tx_byte: a loopback receiver monitor rebuilds each frame
// from the so/so_en strobes and compares it with the words that were loaded.
module tb_serial_tx_byte;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, tick, lv0, lv2;
    logic [W-1:0] din0, din2;
    logic         lr0, so0, soen0, busy0, done0;
    logic         lr2, so2, soen2, busy2, done2;

    serial_tx_byte #(.WIDTH(W), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .load_valid(lv0), .din(din0),
        .load_ready(lr0), .so(so0), .so_en(soen0), .busy(busy0), .done(done0)
    );

    serial_tx_byte #(.WIDTH(W), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .load_valid(lv2), .din(din2),
        .load_ready(lr2), .so(so2), .so_en(soen2), .busy(busy2), .done(done2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int tick_period = 1;   // 0 = random tick

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Loopback receiver model + frame log for dut0
    logic rx_bits[$];
    int   q_word[$], q_par[$], q_cnt[$], q_first[$], q_done[$], q_lr[$];
    int   exp_q[$];
    int   first_c;
    logic prev_so, prev_busy, prev_tick;

    always @(negedge clk) begin
        if (rst) begin
            rx_bits.delete();
            prev_busy = 1'b0;
        end else begin
            if (busy0 && prev_busy && !prev_tick) chk("so_hold", so0, prev_so);
            if (soen0) begin
                chk("strobe_tick", tick, 1);
                chk("strobe_busy", busy0, 1);
                if (rx_bits.size() == 0) first_c = cyc;
                rx_bits.push_back(so0);
            end
            if (done0) begin
                int w;
                int p;
                w = 0;
                p = 0;
                for (int i = 0; i < W; i++)
                    if (i < rx_bits.size()) w |= int'(rx_bits[i]) << i;
                if (rx_bits.size() > W) p = int'(rx_bits[W]);
                chk("done_busy", busy0, 0);
                q_word.push_back(w);
                q_par.push_back(p);
                q_cnt.push_back(rx_bits.size());
                q_first.push_back(first_c);
                q_done.push_back(cyc);
                q_lr.push_back(int'(lr0));
                rx_bits.delete();
            end
            prev_busy = busy0;
        end
        prev_so   = so0;
        prev_tick = tick;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tick_period == 0) tick = 1'($urandom_range(0, 1));
        else                  tick = ((cyc % tick_period) == 0);
    endtask

    // Hold the word until the handshake completes (source-side rule).
    task automatic push_word(input logic [W-1:0] w, output int acc_cyc);
        bit acc;
        acc     = 1'b0;
        acc_cyc = -1;
        din0    = w;
        lv0     = 1'b1;
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            if (lr0) begin
                acc     = 1'b1;
                acc_cyc = cyc;
            end
            step();
        end
        lv0 = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
        else      exp_q.push_back(int'(w));
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (q_word.size() < n && k < 1000) begin
            step();
            k++;
        end
        if (q_word.size() < n) chk("done_timeout", q_word.size(), n);
    endtask

    task automatic check_frame(input string tag, output int f_c, output int d_c);
        int           w, p, c, lr, e;
        logic [W-1:0] ew;
        if (q_word.size() == 0 || exp_q.size() == 0) begin
            chk({tag, "_missing"}, 0, 1);
            f_c = 0;
            d_c = 0;
            return;
        end
        w   = q_word.pop_front();
        p   = q_par.pop_front();
        c   = q_cnt.pop_front();
        f_c = q_first.pop_front();
        d_c = q_done.pop_front();
        lr  = q_lr.pop_front();
        e   = exp_q.pop_front();
        ew  = e[W-1:0];
        chk({tag, "_word"}, w, e);
        chk({tag, "_cnt"}, c, NB);
        chk({tag, "_ready"}, lr, 1);
`ifdef SERIAL_TX_PARITY_EN
        chk({tag, "_par"}, p, int'(^ew));
`else
        chk({tag, "_nopar"}, p, 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, a2, f, d, f2, d2, nd;
        bit seen;
        rst = 1'b1; tick = 1'b0; lv0 = 1'b0; lv2 = 1'b0; din0 = '0; din2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_so", so0, 0);
        chk("rst_soen", soen0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_ready0", lr0, 1);
        chk("rel_ready2", lr2, 1);
        @(posedge clk);
        #1;

        // Basic frame, tick always high
        tick_period = 1; tick = 1'b1;
        push_word(8'hA5, a);
        wait_done(1);
        check_frame("basic", f, d);
        chk("basic_first", f - a, 1);
        chk("basic_done", d - a, NB + 1);

        // Slow tick
        tick_period = 3;
        push_word(8'h81, a);
        wait_done(1);
        check_frame("slow", f, d);

        // Back-to-back, GAP=0
        tick_period = 1; tick = 1'b1;
        push_word(8'h3C, a);
        push_word(8'hC3, a2);
        wait_done(2);
        check_frame("b2b1", f, d);
        check_frame("b2b2", f2, d2);
        chk("b2b_acc_in_done", a2, d);
        chk("b2b_one_idle", f2 - d, 1);

        // GAP=2 on the second instance
        din2 = 8'h55; lv2 = 1'b1;
        step();
        lv2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
            else step();
        end
        chk("gap_done_seen", seen, 1);
        chk("gap_d0_ready", lr2, 0);
        chk("gap_d0_busy", busy2, 1);
        step();
        @(negedge clk);
        chk("gap_d1_ready", lr2, 0);
        chk("gap_d1_soen", soen2, 0);
        chk("gap_d1_so", so2, 0);
        step();
        @(negedge clk);
        chk("gap_d2_ready", lr2, 1);
        chk("gap_d2_busy", busy2, 0);
        step();

        // Reset in the middle of a frame
        push_word(8'hFF, a);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (rx_bits.size() >= 4) seen = 1'b1;
            else step();
        end
        chk("mid_seen", seen, 1);
        rst = 1'b1;
        #1;
        chk("mid_so", so0, 0);
        chk("mid_soen", soen0, 0);
        chk("mid_busy", busy0, 0);
        chk("mid_done", done0, 0);
        nd = q_word.size();
        step();
        step();
        rst = 1'b0;
        repeat (12) step();
        chk("mid_nodone", q_word.size(), nd);
        exp_q.delete();
        push_word(8'h0F, a);
        wait_done(1);
        check_frame("after_rst", f, d);

`ifdef SERIAL_TX_PARITY_EN
        tick_period = 1; tick = 1'b1;
        push_word(8'h07, a);
        wait_done(1);
        check_frame("par07", f, d);
        chk("par07_done", d - a, NB + 1);
        push_word(8'h03, a);
        wait_done(1);
        check_frame("par03", f, d);
`endif

        // Random words, random tick, random load spacing
        tick_period = 0;
        for (int i = 0; i < 12; i++) begin
            push_word(W'($urandom), a);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) step();
        end
        wait_done(12);
        for (int i = 0; i < 12; i++) check_frame("rand", f, d);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
